// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the accumulator sequencer and its sub-modules.
//   W       : default datapath width; must match the attached 4-bit ALU.
//   REP_W   : default width of the repeat field.
//   OP_*    : ALU opcodes, encoded as {L,M,N}.
//   seqState: sequencer FSM states.
package alu_pkg;

  localparam int W     = 4;
  localparam int REP_W = 2;

  localparam logic [2:0] OP_NEGA = 3'b000;  // -A
  localparam logic [2:0] OP_NEGB = 3'b001;  // -B
  localparam logic [2:0] OP_ADD  = 3'b010;  // A+B
  localparam logic [2:0] OP_SUB  = 3'b011;  // A-B
  localparam logic [2:0] OP_AND  = 3'b100;  // A&B
  localparam logic [2:0] OP_OR   = 3'b101;  // A|B
  localparam logic [2:0] OP_MUL  = 3'b110;  // A*B, low W bits
  localparam logic [2:0] OP_XOR  = 3'b111;  // A^B

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seqState;

endpackage

// File: rtl/alu_rep_counter.sv
// alu_rep_counter: remaining-iteration counter for the sequencer.
//   clk, rst_n : clock, asynchronous active-low reset (count returns to 0).
//   load       : capture loadVal (takes priority over dec).
//   loadVal    : repeat count minus 1 from the accepted command.
//   dec        : decrement by one.
//   isZero     : count is zero, i.e. the current iteration is the last one.
module alu_rep_counter #(
  parameter int REP_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [REP_W-1:0] loadVal,
  input  logic             dec,
  output logic             isZero
);

  logic [REP_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign isZero = (cnt == '0);

endmodule

// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer: accumulator and command sequencer around a 4-bit
// combinational ALU. A command either loads the accumulator or applies an
// ALU opcode (A = accumulator, B = latched operand) cmd_reps+1 times; the
// final accumulator is returned on the response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds cmd_* stable while cmd_valid is high and
// cmd_ready is low; rsp_valid/rsp_acc/rsp_zero stay stable until rsp_ready.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_load               1 = load cmd_operand, ALU unused
//   cmd_op                 ALU opcode {L,M,N}
//   cmd_operand            operand B / load value
//   cmd_reps               repeat count minus 1
//   alu_a, alu_b           ALU operands (accumulator, latched operand)
//   alu_l, alu_m, alu_n    ALU opcode bits
//   alu_s                  ALU result
//   rsp_valid/rsp_ready    response handshake
//   rsp_acc, rsp_zero      accumulator value and its zero flag
//   rsp_ovf                sticky signed overflow (only with ALU_ACC_OVF_EN)
//   dbgState               current FSM state (seqState encoding)
//
// Build option: define ALU_ACC_OVF_EN to add rsp_ovf.
module alu_acc_sequencer
  import alu_pkg::*;
#(
  parameter int W     = alu_pkg::W,
  parameter int REP_W = alu_pkg::REP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_operand,
  input  logic [REP_W-1:0] cmd_reps,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_l,
  output logic             alu_m,
  output logic             alu_n,
  input  logic [W-1:0]     alu_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_acc,
  output logic             rsp_zero,
`ifdef ALU_ACC_OVF_EN
  output logic             rsp_ovf,
`endif
  output logic [1:0]       dbgState
);

  seqState state, stateNext;

  logic [W-1:0] acc;
  logic [2:0]   opQ;
  logic [W-1:0] opndQ;
  logic         zeroQ;
  logic         accept;
  logic         repLast;

  // FSM next-state logic
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          stateNext = cmd_load ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (repLast) stateNext = RESP;
      end
      RESP: begin
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Datapath registers. zeroQ is written alongside every accumulator write
  // so rsp_zero never needs a comparator on the output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opQ   <= '0;
      opndQ <= '0;
      zeroQ <= 1'b1;
    end else if (accept) begin
      opQ   <= cmd_op;
      opndQ <= cmd_operand;
      if (cmd_load) begin
        acc   <= cmd_operand;
        zeroQ <= (cmd_operand == '0);
      end
    end else if (state == EXEC) begin
      acc   <= alu_s;
      zeroQ <= (alu_s == '0);
    end
  end

  alu_rep_counter #(.REP_W(REP_W)) uRepCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .loadVal (cmd_reps),
    .dec     ((state == EXEC) && !repLast),
    .isZero  (repLast)
  );

`ifdef ALU_ACC_OVF_EN
  // Signed overflow of the current iteration, judged from sign bits only.
  logic iterOvf;
  always_comb begin
    iterOvf = 1'b0;
    if (opQ == OP_ADD)
      iterOvf = (acc[W-1] == opndQ[W-1]) && (alu_s[W-1] != acc[W-1]);
    else if (opQ == OP_SUB)
      iterOvf = (acc[W-1] != opndQ[W-1]) && (alu_s[W-1] != acc[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               rsp_ovf <= 1'b0;
    else if (accept)          rsp_ovf <= 1'b0;
    else if (state == EXEC)   rsp_ovf <= rsp_ovf | iterOvf;
  end
`endif

  assign cmd_ready             = (state == IDLE);
  assign rsp_valid             = (state == RESP);
  assign rsp_acc               = acc;
  assign rsp_zero              = zeroQ;
  assign alu_a                 = acc;
  assign alu_b                 = opndQ;
  assign {alu_l, alu_m, alu_n} = opQ;
  assign dbgState              = state;

endmodule

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
Accumulator and command sequencer wrapped around the 4-bit combinational ALU.
- Accepts commands over a valid/ready handshake.
- Drives the ALU with A = accumulator, B = command operand and the opcode on L/M/N.
- Captures S back into the accumulator, optionally repeating the operation up to 4 times.
- Returns the final accumulator value over a valid/ready response channel.
- Sits both upstream of the ALU (driving its operands and opcode) and downstream of it (consuming S).

Parameters:
- W, 4, datapath width; must match the ALU width.
- REP_W, 2, width of the repeat field; the operation executes cmd_reps+1 times.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_load  in  1  1 = load cmd_operand into the accumulator; ALU not used.
- cmd_op  in  3  ALU opcode {L,M,N}.
- cmd_operand  in  W  operand B.
- cmd_reps  in  REP_W  repeat count minus 1.
- alu_a  out  W  ALU operand A (accumulator).
- alu_b  out  W  ALU operand B (latched operand).
- alu_l, alu_m, alu_n  out  1 each  ALU control bits.
- alu_s  in  W  ALU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_acc  out  W  accumulator value.
- rsp_zero  out  1  rsp_acc == 0.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Opcode map {L,M,N}:
  - 000 = -A
  - 001 = -B
  - 010 = A+B
  - 011 = A-B
  - 100 = A&B
  - 101 = A|B
  - 110 = A*B (low W bits)
  - 111 = A^B
- All arithmetic is mod 2^W.
- Reset values: state=IDLE, acc=0, op_q=0, opnd_q=0, rep_cnt=0, rsp_valid=0, rsp_zero=1, alu_l/m/n=0. cmd_ready=1 (it is decoded from IDLE).
- Outputs alu_a=acc and alu_b=opnd_q always; {alu_l,alu_m,alu_n}=op_q always.
- States: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch op_q, opnd_q, rep_cnt=cmd_reps.
  - If cmd_load: acc<=cmd_operand, go to RESP. Otherwise go to EXEC.
- EXEC:
  - cmd_ready=0.
  - Each cycle: acc<=alu_s (ALU path is single-cycle combinational).
  - If rep_cnt==0, go to RESP; otherwise rep_cnt decrements.
  - Occupancy is cmd_reps+1 cycles.
- RESP:
  - rsp_valid=1, and rsp_acc/rsp_zero are held stable until rsp_ready.
  - On rsp_ready: rsp_valid<=0, go to IDLE.
  - The next command can be accepted the cycle after the response handshake; commands are never accepted in RESP.
- Latency, command accept (cycle 0) to rsp_valid:
  - ALU command: cmd_reps+2 cycles.
  - Load: 1 cycle.
- rsp_zero is registered, updated with every accumulator write.
- Reset asserted in any state (including mid-EXEC): all registers return to reset values immediately. Any partial result is discarded and no response is produced.
- cmd_valid while not in IDLE is ignored; the command must be held by the producer.

Optional Feature:
- Macro: ALU_ACC_OVF_EN.
- When defined:
  - Adds output rsp_ovf (1 bit, reset 0): a sticky signed-overflow flag over all iterations of the current command.
  - For op 010: overflow when the sign bits of A and B match and S's sign differs.
  - For op 011: overflow when the sign bits of A and B differ and S's sign differs from A's.
  - Cleared on command accept; held with the response.
  - Other ops never set it.
- When undefined: the port and its logic are absent.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_NEGA, OP_NEGB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_XOR;
  - the state enum type (IDLE/EXEC/RESP);
  - the W default.
- One natural sub-module: alu_rep_counter (load, decrement, zero detect).
- The bench instantiates the existing ALU as the alu_s source.

Test Plan:
- Load 3, then op 010 operand 5 reps 0 -> rsp_acc=8, rsp_zero=0, rsp_valid 2 cycles after accept.
- From acc 8: op 011 operand 8 reps 2 -> iterations give 0, 8, 0 -> rsp_acc=0, rsp_zero=1, latency 4.
- Load 2, then op 110 operand 3 reps 1 -> 6 then 18 mod 16 -> rsp_acc=2.
- Hold rsp_ready=0 for 3 cycles -> rsp_valid and rsp_acc stable, cmd_ready=0, new cmd_valid ignored. Release -> IDLE next cycle.
- Assert rst_n=0 in the second EXEC cycle of a reps=3 command -> acc=0, state IDLE, rsp_valid never pulses.
- (ALU_ACC_OVF_EN) Load 7, op 010 operand 1 -> rsp_acc=8, rsp_ovf=1. Next command: op 100 operand 15 -> rsp_ovf=0.
